// File: rtl/call_return_ctrl.sv
// Return-address-stack master: turns CALL/RET requests into push/pop strobes and PC loads.
// CALL loads the PC 1 cycle after accept, RET 2 cycles after; instr_ready is low while busy and forever after a fault.
module call_return_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 8,
    parameter int RET_OFFSET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] target,
    output logic              stack_push,
    output logic [ADDR_W-1:0] stack_wdata,
    output logic              stack_pop,
    input  logic [ADDR_W-1:0] stack_rdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, CALL, RPOP, RWAIT, FAULT} state_t;

    state_t              state, stateNext;
    logic [DEPTH_W-1:0]  depth;
    logic [1:0]          codeNext;
    logic [ADDR_W-1:0]   pcNextReg;
    logic                handshake;

    assign instr_ready = (state == IDLE);
    assign handshake   = instr_valid & instr_ready;

    always_comb begin
        stateNext = state;
        codeNext  = fault_code;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (is_call && is_ret) begin
                        stateNext = FAULT;
                        codeNext  = 2'b11;
                    end else if (is_call) begin
                        if (depth == DEPTH_W'(DEPTH)) begin
                            stateNext = FAULT;
                            codeNext  = 2'b01;
                        end else begin
                            stateNext = CALL;
                        end
                    end else if (is_ret) begin
                        if (depth == '0) begin
                            stateNext = FAULT;
                            codeNext  = 2'b10;
                        end else begin
                            stateNext = RPOP;
                        end
                    end
                end
            end
            CALL:    stateNext = IDLE;
            RPOP:    stateNext = RWAIT;
            RWAIT:   stateNext = IDLE;
            FAULT:   stateNext = FAULT;
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up exactly with CALL/RPOP/RWAIT/FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            depth       <= '0;
            stack_push  <= 1'b0;
            stack_pop   <= 1'b0;
            pc_load     <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
            stack_wdata <= '0;
            pcNextReg   <= '0;
        end else begin
            state      <= stateNext;
            fault_code <= codeNext;
            stack_push <= (stateNext == CALL);
            stack_pop  <= (stateNext == RPOP);
            pc_load    <= (stateNext == CALL) || (stateNext == RWAIT);
            fault      <= (stateNext == FAULT);
            if (state == CALL) begin
                depth <= depth + 1'b1;
            end else if (state == RPOP) begin
                depth <= depth - 1'b1;
            end
            if (handshake && is_call && !is_ret) begin
                stack_wdata <= pc_in + ADDR_W'(RET_OFFSET);
                pcNextReg   <= target;
            end else if (state == RWAIT) begin
                pcNextReg <= stack_rdata;
            end
        end
    end

    // Stack read data only arrives in RWAIT, so it is forwarded straight to pc_next there.
    assign pc_next = (state == RWAIT) ? stack_rdata : pcNextReg;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Randomized scoreboard bench for call_return_ctrl with a behavioural stack/PC model.
module tb_call_return_ctrl;

    localparam int AW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid, instr_ready, is_call, is_ret;
    logic [AW-1:0] pc_in, target;
    logic          stack_push, stack_pop, pc_load, fault;
    logic [AW-1:0] stack_wdata, pc_next;
    logic [AW-1:0] stack_rdata = '0;
    logic [1:0]    fault_code;

    always #5 clk = ~clk;

    call_return_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .RET_OFFSET(1)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .is_call(is_call), .is_ret(is_ret), .pc_in(pc_in), .target(target),
        .stack_push(stack_push), .stack_wdata(stack_wdata),
        .stack_pop(stack_pop), .stack_rdata(stack_rdata),
        .pc_load(pc_load), .pc_next(pc_next),
        .fault(fault), .fault_code(fault_code)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        push;
        logic        pop;
        logic        load;
        logic [31:0] wdata;
        logic [31:0] pnext;
        logic        flt;
        logic [1:0]  code;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] retQ[$];
    logic [31:0] stk[$];
    int          nChecks = 0;
    int          nFails = 0;
    int unsigned cyc = 0;
    int          mDepth = 0;
    bit          mFault = 0;
    int unsigned mReadyAt = 0;
    bit          prevFault = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    // Stack: registered read data, valid the cycle after the pop.
    always @(posedge clk) begin
        if (reset) begin
            stk.delete();
        end else begin
            if (stack_push) begin
                chk("push_not_full", stk.size() < DEPTH, 1'b1);
                if (stk.size() < DEPTH) stk.push_back(stack_wdata);
            end
            if (stack_pop) begin
                chk("pop_not_empty", stk.size() > 0, 1'b1);
                if (stk.size() > 0) stack_rdata <= stk.pop_back();
            end
        end
    end

    // Monitor: any strobe or a rising fault consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t a, e;
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            nChecks++;
            nFails++;
            $display("FAIL missed_output: nothing seen, expected %h at cycle %0d", e, e.cyc);
        end
        if (stack_push || stack_pop || pc_load || (fault && !prevFault)) begin
            a       = '0;
            a.cyc   = cyc;
            a.push  = stack_push;
            a.pop   = stack_pop;
            a.load  = pc_load;
            if (stack_push) a.wdata = stack_wdata;
            if (pc_load)    a.pnext = pc_next;
            a.flt   = fault;
            a.code  = fault_code;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_output: got %h, expected no activity", a);
            end else begin
                e = expQ.pop_front();
                chk("output", a, e);
            end
        end
        prevFault = fault;
    end

    task automatic drive_idle();
        instr_valid = 1'b0;
        is_call     = 1'($urandom);
        is_ret      = 1'($urandom);
        pc_in       = $urandom;
        target      = $urandom;
    endtask

    task automatic check_ready();
        chk("instr_ready", instr_ready, (!mFault && cyc >= mReadyAt));
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            drive_idle();
            @(negedge clk);
            check_ready();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        int unsigned now;
        now   = cyc;
        reset = 1'b1;
        drive_idle();
        for (int i = expQ.size() - 1; i >= 0; i--)
            if (expQ[i].cyc > now) expQ.delete(i);
        retQ.delete();
        mDepth   = 0;
        mFault   = 0;
        mReadyAt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {instr_ready, stack_push, stack_pop, pc_load, fault, fault_code, stack_wdata, pc_next},
            {1'b1, 4'b0000, 2'b00, 32'h0, 32'h0});
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic c, input logic r, input logic [31:0] pc, input logic [31:0] tg);
        exp_t        e;
        int unsigned n;
        int          guard = 0;
        if (mFault) return;
        instr_valid = 1'b1;
        is_call     = c;
        is_ret      = r;
        pc_in       = pc;
        target      = tg;
        @(negedge clk);
        check_ready();
        while (cyc < mReadyAt && guard < 8) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_ready();
            guard++;
        end
        n = cyc;
        e = '0;
        e.cyc = n + 1;
        if (c && r) begin
            e.flt = 1'b1; e.code = 2'b11; mFault = 1;
            expQ.push_back(e);
        end else if (c) begin
            if (mDepth == DEPTH) begin
                e.flt = 1'b1; e.code = 2'b01; mFault = 1;
                expQ.push_back(e);
            end else begin
                e.push = 1'b1; e.load = 1'b1; e.wdata = pc + 32'd1; e.pnext = tg;
                expQ.push_back(e);
                retQ.push_back(pc + 32'd1);
                mDepth++;
                mReadyAt = n + 2;
            end
        end else if (r) begin
            if (mDepth == 0) begin
                e.flt = 1'b1; e.code = 2'b10; mFault = 1;
                expQ.push_back(e);
            end else begin
                e.pop = 1'b1;
                expQ.push_back(e);
                e       = '0;
                e.cyc   = n + 2;
                e.load  = 1'b1;
                e.pnext = retQ.pop_back();
                expQ.push_back(e);
                mDepth--;
                mReadyAt = n + 3;
            end
        end else begin
            mReadyAt = n + 1;
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        drive_idle();
        do_reset();
        // Basic CALL then RET round trip.
        issue(1'b1, 1'b0, 32'h10, 32'h40);
        issue(1'b0, 1'b1, 32'h0, 32'h0);
        idle(2);
        // Fill the stack, then overflow.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, $urandom, $urandom);
        issue(1'b1, 1'b0, 32'h1234, 32'h5678);
        idle(4);
        // Underflow.
        do_reset();
        issue(1'b0, 1'b1, 32'h0, 32'h0);
        idle(3);
        // Return address wraps.
        do_reset();
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h100);
        issue(1'b0, 1'b1, 32'h0, 32'h0);
        idle(2);
        // CALL and RET flags together.
        do_reset();
        issue(1'b1, 1'b1, 32'h20, 32'h30);
        idle(3);
        // Reset while in RPOP: the pending PC load is abandoned and depth returns to 0.
        do_reset();
        issue(1'b1, 1'b0, 32'h200, 32'h300);
        issue(1'b0, 1'b1, 32'h0, 32'h0);
        do_reset();
        idle(3);
        issue(1'b0, 1'b1, 32'h0, 32'h0);
        idle(2);
        // Random episodes.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int k = 0; k < 40 && !mFault; k++) begin
                if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
                sel = $urandom_range(31);
                if (sel == 0)       issue(1'b1, 1'b1, $urandom, $urandom);
                else if (sel < 3)   issue(1'b0, 1'b0, $urandom, $urandom);
                else if (sel < 20)  issue(1'b1, 1'b0, $urandom, $urandom);
                else                issue(1'b0, 1'b1, $urandom, $urandom);
            end
            idle(3);
        end
        idle(4);
        chk("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
